// File: rtl/load_store_unit.sv
// Load/store unit: sequences execute-stage load/store requests onto a byte-addressed
// word memory port, with sub-word extension, read-modify-write stores, misalignment and timeout errors.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        stall,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] ReadData,
  input  logic        MemReady
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, ERR, RESP} state_t;

  state_t             state;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [1:0]         lane_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   cnt;
  logic               timed_out;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

  // Pick the addressed lane out of the memory word and sign/zero-extend it.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] size,
                                         input logic uns, input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extend = uns ? {24'b0, b} : 32'(b);
      2'b01:   extend = uns ? {16'b0, h} : 32'(h);
      default: extend = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] size, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (size)
      2'b00:   r[{a, 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    merge = r;
  endfunction

  assign req_ready = (state == IDLE);
  assign stall     = (state != IDLE);
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      Address    <= '0;
      WriteData  <= '0;
      cnt        <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            Address <= {req_addr[31:2], 2'b00};
            rdata_q <= '0;
            err_q   <= 2'b00;
            cnt     <= '0;
            if (misaligned(req_size, req_addr[1:0])) begin
              err_q <= 2'b01;
              state <= ERR;
            end else if (!req_write) begin
              MemRead <= 1'b1;
              state   <= RD;
            end else if (req_size[1] == 1'b0) begin
              MemRead <= 1'b1;
              state   <= RMW_RD;
            end else begin
              MemWrite  <= 1'b1;
              WriteData <= req_wdata;
              state     <= WR;
            end
          end
        end
        RD: begin
          if (MemReady) begin
            MemRead <= 1'b0;
            rdata_q <= extend(ReadData, size_q, uns_q, lane_q);
            state   <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timed_out) begin
              MemRead <= 1'b0;
              err_q   <= 2'b10;
              state   <= RESP;
            end
          end
        end
        RMW_RD: begin
          // The old word arrives here; the write phase reuses the same address.
          if (MemReady) begin
            MemRead   <= 1'b0;
            MemWrite  <= 1'b1;
            WriteData <= merge(ReadData, wdata_q, size_q, lane_q);
            cnt       <= '0;
            state     <= WR;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timed_out) begin
              MemRead <= 1'b0;
              err_q   <= 2'b10;
              state   <= RESP;
            end
          end
        end
        WR: begin
          if (MemReady) begin
            MemWrite <= 1'b0;
            state    <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (timed_out) begin
              MemWrite <= 1'b0;
              err_q    <= 2'b10;
              state    <= RESP;
            end
          end
        end
        ERR: state <= RESP;
        RESP: begin
          resp_valid <= 1'b1;
          resp_rdata <= rdata_q;
          resp_err   <= err_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        stall;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic        MemReady;

  logic        mem_ready = 1'b1;
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int rv_cnt = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .MemReady(MemReady)
  );

  always #5 clk = ~clk;

  assign MemReady = mem_ready;
  assign ReadData = mem[Address[7:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (MemWrite && mem_ready) mem[Address[7:2]] <= WriteData;
  end

  always @(negedge clk) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) wr_cnt++;
    if (MemRead && MemWrite) both_cnt++;
    if (resp_valid) rv_cnt++;
  end

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = addr[7:2]; pre_data = data;
    @(posedge clk);
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where resp_valid is seen (or after the bound).
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic [1:0] er,
                        output int nrd, output int nwr, output logic rdy, output logic [31:0] a0);
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    rdy = req_ready;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    a0 = Address;
    lat = -1; rd = 32'hxxxxxxxx; er = 2'bxx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) begin
        lat = i; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, stall, MemRead, MemWrite} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, stall, MemRead, MemWrite});
    end
    checks++;
    if ({resp_rdata, resp_err, Address, WriteData} !== 98'd0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h want 0", resp_rdata, resp_err, Address, WriteData);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_word;
    int lat, nrd, nwr; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    preload(32'h10, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (a0 !== 32'h10) begin errors++; $display("FAIL lw_address got %h want 00000010", a0); end
    checks++;
    if (nrd !== 1 || nwr !== 0) begin errors++; $display("FAIL lw_strobes got rd=%0d wr=%0d want rd=1 wr=0", nrd, nwr); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 2'b00) begin errors++; $display("FAIL lw_data got %h err %b want deadbeef err 00", rd, er); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d want 2", lat); end
  endtask

  task automatic test_load_extend;
    logic [31:0] ad  [6] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h12, 32'h11};
    logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    logic        un  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00000001,
                             32'hFFFF80FF, 32'h000080FF, 32'h0000007F};
    int lat, nrd, nwr; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    preload(32'h10, 32'h80FF7F01);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
      checks++;
      if (rd !== exp[i] || er !== 2'b00 || lat !== 2) begin
        errors++; $display("FAIL load_ext[%0d] got %h err %b lat %0d want %h err 00 lat 2", i, rd, er, lat, exp[i]);
      end
    end
  endtask

  task automatic test_store;
    int lat, nrd, nwr; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    preload(32'h20, 32'h11223344);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (mem[8] !== 32'hABCD3344) begin errors++; $display("FAIL sh_merge got %h want abcd3344", mem[8]); end
    checks++;
    if (lat !== 3 || er !== 2'b00 || rd !== 32'h0 || nrd !== 1 || nwr !== 1) begin
      errors++; $display("FAIL sh_seq got lat %0d err %b rdata %h rd=%0d wr=%0d want 3 00 0 1 1", lat, er, rd, nrd, nwr);
    end
    do_req(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (mem[8] !== 32'hABCD5A44 || lat !== 3) begin
      errors++; $display("FAIL sb_merge got %h lat %0d want abcd5a44 lat 3", mem[8], lat);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (mem[9] !== 32'hCAFEF00D || lat !== 2 || nrd !== 0 || nwr !== 1) begin
      errors++; $display("FAIL sw got %h lat %0d rd=%0d wr=%0d want cafef00d 2 0 1", mem[9], lat, nrd, nwr);
    end
  endtask

  task automatic test_misaligned;
    int lat, nrd, nwr; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (er !== 2'b01 || rd !== 32'h0 || lat !== 2 || nrd !== 0 || nwr !== 0) begin
      errors++; $display("FAIL lw_misaligned got err %b rdata %h lat %0d rd=%0d wr=%0d want 01 0 2 0 0", er, rd, lat, nrd, nwr);
    end
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (er !== 2'b01 || rd !== 32'h0 || nrd !== 0 || nwr !== 0 || mem[8] !== 32'hABCD5A44) begin
      errors++; $display("FAIL sh_misaligned got err %b rdata %h rd=%0d wr=%0d mem %h want 01 0 0 0 abcd5a44", er, rd, nrd, nwr, mem[8]);
    end
  endtask

  task automatic test_timeout;
    int lat, nrd, nwr; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    preload(32'h30, 32'h55667788);
    mem_ready = 1'b0;
    do_req(1'b1, 2'b00, 1'b0, 32'h30, 32'h000000AA, lat, rd, er, nrd, nwr, rdy, a0);
    mem_ready = 1'b1;
    checks++;
    if (nrd !== 16 || nwr !== 0) begin errors++; $display("FAIL timeout_strobes got rd=%0d wr=%0d want 16 0", nrd, nwr); end
    checks++;
    if (er !== 2'b10 || lat !== 17 || mem[12] !== 32'h55667788) begin
      errors++; $display("FAIL timeout_resp got err %b lat %0d mem %h want 10 17 55667788", er, lat, mem[12]);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (rd !== 32'h55667788 || er !== 2'b00 || lat !== 2) begin
      errors++; $display("FAIL after_timeout got %h err %b lat %0d want 55667788 00 2", rd, er, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nrd, nwr; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    do_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
    do_req(1'b0, 2'b01, 1'b1, 32'h26, 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (rdy !== 1'b1 || rd !== 32'h0000CAFE || lat !== 2) begin
      errors++; $display("FAIL back_to_back got ready %b data %h lat %0d want 1 0000cafe 2", rdy, rd, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nrd, nwr, rv0; logic [31:0] rd, a0; logic [1:0] er; logic rdy;
    preload(32'h40, 32'h0BADF00D);
    mem_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (MemWrite !== 1'b1) begin errors++; $display("FAIL mid_wr_active got %b want 1", MemWrite); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({MemWrite, MemRead, stall, req_ready} !== 4'b0001) begin
      errors++; $display("FAIL async_reset got %b want 0001", {MemWrite, MemRead, stall, req_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b1;
    rv0 = rv_cnt;
    repeat (4) @(negedge clk);
    checks++;
    if (rv_cnt - rv0 !== 0 || mem[16] !== 32'h0BADF00D) begin
      errors++; $display("FAIL reset_no_resp got pulses %0d mem %h want 0 0badf00d", rv_cnt - rv0, mem[16]);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, rd, er, nrd, nwr, rdy, a0);
    checks++;
    if (rd !== 32'h0BADF00D || er !== 2'b00 || lat !== 2) begin
      errors++; $display("FAIL after_reset got %h err %b lat %0d want 0badf00d 00 2", rd, er, lat);
    end
  endtask

  task automatic test_strobe_exclusive;
    checks++;
    if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", both_cnt); end
  endtask

  initial begin
    test_reset;
    test_load_word;
    test_load_extend;
    test_store;
    test_misaligned;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_strobe_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
